// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared ALU: one operation in flight, fixed ALU latency.
// Optional macro ALU_ARB_OPCHECK_EN rejects unsupported opcodes with an error response.
module alu_arbiter #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Req0Valid,
  input  logic        Req1Valid,
  input  logic [5:0]  Req0OPCode,
  input  logic [5:0]  Req1OPCode,
  input  logic [31:0] Req0DataA,
  input  logic [31:0] Req0DataB,
  input  logic [31:0] Req1DataA,
  input  logic [31:0] Req1DataB,
  output logic        Req0Ready,
  output logic        Req1Ready,
  output logic [5:0]  AluOPCode,
  output logic [31:0] AluDataA,
  output logic [31:0] AluDataB,
  input  logic [31:0] AluResultC,
  input  logic [3:0]  AluStatus,
  output logic        RespValid,
  output logic        RespId,
  output logic [31:0] RespResultC,
  output logic [3:0]  RespStatus,
  output logic        RespError,
  input  logic        RespReady
);

  // state  | meaning
  // IDLE   | no operation in flight; arbitrate and grant
  // ISSUE  | operands launched to the ALU this cycle
  // WAIT   | counting down the ALU latency
  // RESP   | response held until the consumer accepts
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        own_q, own_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  alu_op_q, alu_op_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_id_q, resp_id_d;
  logic [31:0] resp_c_q, resp_c_d;
  logic [3:0]  resp_s_q, resp_s_d;
  logic        resp_err_q, resp_err_d;

  logic        grant_any, grant_id, op_ok;
  logic [5:0]  op_sel;
  logic [31:0] a_sel, b_sel;

  always_comb begin
    grant_any = Req0Valid | Req1Valid;
    // preferred requester wins; the other only when the preferred one is idle
    grant_id  = ptr_q ? Req1Valid : ~Req0Valid;
    op_sel    = grant_id ? Req1OPCode : Req0OPCode;
    a_sel     = grant_id ? Req1DataA  : Req0DataA;
    b_sel     = grant_id ? Req1DataB  : Req0DataB;
`ifdef ALU_ARB_OPCHECK_EN
    op_ok = op_sel inside {6'b010000, 6'b010001, 6'b010010, 6'b010011, 6'b001100, 6'b001101};
`else
    op_ok = 1'b1;
`endif
  end

  assign Req0Ready = ~Reset & (state_q == IDLE) & grant_any & ~grant_id;
  assign Req1Ready = ~Reset & (state_q == IDLE) & grant_any &  grant_id;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    own_d        = own_q;
    cnt_d        = cnt_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_c_d     = resp_c_q;
    resp_s_d     = resp_s_q;
    resp_err_d   = resp_err_q;
    unique case (state_q)
      IDLE: begin
        if (grant_any) begin
          ptr_d = ~grant_id;
          own_d = grant_id;
          if (op_ok) begin
            alu_op_d = op_sel;
            alu_a_d  = a_sel;
            alu_b_d  = b_sel;
            state_d  = ISSUE;
          end else begin
            // rejected opcode: ALU never sees it, answer immediately
            resp_valid_d = 1'b1;
            resp_id_d    = grant_id;
            resp_c_d     = '0;
            resp_s_d     = '0;
            resp_err_d   = 1'b1;
            state_d      = RESP;
          end
        end
      end
      ISSUE: begin
        cnt_d   = 4'(ALU_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          resp_valid_d = 1'b1;
          resp_id_d    = own_q;
          resp_c_d     = AluResultC;
          resp_s_d     = AluStatus;
          resp_err_d   = 1'b0;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (RespReady) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      own_q        <= 1'b0;
      cnt_q        <= '0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_c_q     <= '0;
      resp_s_q     <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      own_q        <= own_d;
      cnt_q        <= cnt_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_c_q     <= resp_c_d;
      resp_s_q     <= resp_s_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign AluOPCode   = alu_op_q;
  assign AluDataA    = alu_a_q;
  assign AluDataB    = alu_b_q;
  assign RespValid   = resp_valid_q;
  assign RespId      = resp_id_q;
  assign RespResultC = resp_c_q;
  assign RespStatus  = resp_s_q;
`ifdef ALU_ARB_OPCHECK_EN
  assign RespError   = resp_err_q;
`else
  assign RespError   = 1'b0;
`endif

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter ALU_LAT, default 1: clock edges from operand issue until the shared ALU's ResultC/Status are valid, legal range 1-15.
REQ-002 The block SHALL have these ports, in order:
- Clock  in  1  system clock, all state on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Req0Valid / Req1Valid  in  1  requester 0/1 holds a pending operation.
- Req0OPCode / Req1OPCode  in  6  requester opcode.
- Req0DataA / Req0DataB / Req1DataA / Req1DataB  in  32  requester operands.
- Req0Ready / Req1Ready  out  1  single-cycle accept pulse to the granted requester.
- AluOPCode  out  6  opcode driven to the shared ALU.
- AluDataA / AluDataB  out  32  operands driven to the shared ALU.
- AluResultC  in  32  ALU result.
- AluStatus  in  4  ALU flags (Over, Carry, Zero, Neg).
- RespValid  out  1  response held for the requester.
- RespId  out  1  requester index owning the response.
- RespResultC  out  32  captured result.
- RespStatus  out  4  captured flags.
- RespError  out  1  opcode rejected (Configuration only; else 0).
- RespReady  in  1  response consumer accepts.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP; one operation in flight at a time.
REQ-004 In IDLE with any ReqNValid high, the block SHALL grant one requester, pulse its ReqNReady for exactly that cycle, register its opcode/operands and index, and go to ISSUE.
REQ-005 Arbitration SHALL be round-robin: a one-bit priority pointer names the preferred requester; the non-preferred one is granted only when the preferred one is not valid; both valid in the same cycle: the preferred one wins.
REQ-006 The pointer SHALL switch to the other requester on every grant, so back-to-back dual requests alternate 0,1,0,1.
REQ-007 AluOPCode/AluDataA/AluDataB SHALL be driven from registered values, stable from ISSUE entry until WAIT exit; between operations they keep their last value.
REQ-008 ISSUE SHALL last one cycle, then go to WAIT with a 4-bit counter loaded with ALU_LAT-1.
REQ-009 WAIT SHALL decrement the counter each cycle; at zero, capture AluResultC/AluStatus into RespResultC/RespStatus, set RespValid and RespId, and go to RESP.
REQ-010 The ISSUE-to-capture latency SHALL be ALU_LAT+1 cycles: ALU_LAT=1 captures on the second edge after ISSUE entry.
REQ-011 In RESP, RespValid and all Resp* outputs SHALL hold stable until RespReady is high; on that edge RespValid SHALL clear and the FSM SHALL return to IDLE.
REQ-012 Grant SHALL be evaluated only in IDLE; requests in other states wait and are not dropped; no new grant is made on the RESP-exit edge.
REQ-013 Minimum throughput SHALL be one operation per ALU_LAT+3 cycles with RespReady tied high.
REQ-014 ReqNReady SHALL never be high in any state except IDLE, and never for both requesters in the same cycle.

Reset
REQ-015 Reset high at a rising edge SHALL force IDLE, pointer=0, counter=0, Req0Ready=Req1Ready=0, RespValid=0, RespId=0, RespResultC=0, RespStatus=0, RespError=0, AluOPCode=0, AluDataA=0, AluDataB=0.
REQ-016 Reset in ISSUE/WAIT/RESP SHALL abandon the in-flight operation with no response; its requester must re-request.

Configuration
REQ-017 With macro ALU_ARB_OPCHECK_EN defined, a granted opcode outside {010000, 010001, 010010, 010011, 001100, 001101} SHALL skip ISSUE/WAIT and go straight to RESP with RespError=1, RespResultC=0, RespStatus=0, ALU outputs unchanged.
REQ-018 Without ALU_ARB_OPCHECK_EN, every opcode SHALL be issued normally and RespError SHALL be constant 0.

Verification
REQ-019 Reset, then Req0Valid=1, opcode 010000, A=5, B=7, ALU model returns 12 -> Req0Ready pulse, RespValid after ALU_LAT+1 cycles, RespId=0, RespResultC=12.
REQ-020 Both valid continuously, RespReady=1 -> grants alternate 0,1,0,1 from reset (pointer 0 first); never both Ready in one cycle.
REQ-021 RespReady held low 5 cycles in RESP while Req1Valid=1 -> Resp* stable, Req1Ready stays 0 until RESP exits, then Req1 granted in next IDLE cycle.
REQ-022 Reset asserted in WAIT -> next cycle IDLE, RespValid=0, all REQ-015 values.
REQ-023 ALU_ARB_OPCHECK_EN defined, opcode 111111 -> RespValid one cycle after grant, RespError=1, RespResultC=0, AluOPCode unchanged; undefined -> issued, RespError=0.
REQ-024 ALU_LAT=3 -> capture exactly 4 cycles after ISSUE entry, AluDataA/B stable throughout.
